// File: rtl/rst_seq.sv
// rst_seq: async-assert / sync-release reset sequencer that releases channels in index order.
// Optional macro RST_SEQ_READY_EN gates each release on the previous channel's i_ch_rdy.
module rst_seq #(
    parameter int G_NUM_CH      = 4,
    parameter int G_SYNC_STAGES = 2,
    parameter int G_MIN_ASSERT  = 16,
    parameter int G_REL_GAP     = 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_sw_rst,
`ifdef RST_SEQ_READY_EN
    input  logic [G_NUM_CH-1:0] i_ch_rdy,
`endif
    output logic [G_NUM_CH-1:0] o_rst_n,
    output logic                o_done
);
    localparam int CMAX = (G_MIN_ASSERT > G_REL_GAP) ? G_MIN_ASSERT : G_REL_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1;

    if (G_NUM_CH < 1 || G_SYNC_STAGES < 2 || G_MIN_ASSERT < 1 || G_REL_GAP < 1) begin : g_bad_param
        $error("rst_seq: illegal parameter set");
    end

    typedef enum logic [1:0] {ST_RST, ST_HOLD, ST_REL, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [G_SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]         cnt_q, cnt_d, hold_cnt;
    logic [IW-1:0]         idx_q, idx_d;
    logic [G_NUM_CH-1:0]   rst_q, rst_d;
    logic                  done_q, done_d;
    logic                  srst_n, gap_ok, rdy_ok;

    assign sync_d = {sync_q[G_SYNC_STAGES-2:0], 1'b1};
    assign srst_n = sync_q[G_SYNC_STAGES-1];
    // The RST->HOLD edge is the first counted hold edge, so HOLD starts from zero there.
    assign hold_cnt = (state_q == ST_HOLD) ? cnt_q : '0;
    assign gap_ok   = cnt_q >= CW'(G_REL_GAP - 1);
`ifdef RST_SEQ_READY_EN
    assign rdy_ok = i_ch_rdy[idx_q - IW'(1)];
`else
    assign rdy_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (state_q != ST_RST && i_sw_rst) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RST, ST_HOLD: begin
                    if (state_q == ST_HOLD || srst_n) begin
                        if (hold_cnt >= CW'(G_MIN_ASSERT - 1)) begin
                            rst_d[0] = 1'b1;
                            cnt_d    = '0;
                            idx_d    = IW'(1);
                            state_d  = (G_NUM_CH == 1) ? ST_DONE : ST_REL;
                            done_d   = (G_NUM_CH == 1);
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = hold_cnt + CW'(1);
                        end
                    end
                end
                ST_REL: begin
                    if (gap_ok && rdy_ok) begin
                        rst_d = rst_q | (G_NUM_CH'(1) << idx_q);
                        cnt_d = '0;
                        if (idx_q == IW'(G_NUM_CH - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        // Saturate at the gap length while waiting for ready.
                        cnt_d = gap_ok ? CW'(G_REL_GAP) : cnt_q + CW'(1);
                    end
                end
                default: begin
                    rst_d  = '1;
                    done_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            state_q <= ST_RST;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    assign o_rst_n = rst_q;
    assign o_done  = done_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of rst_seq with default parameters and a single-channel variant.
module tb_rst_seq;
    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       i_rst_n = 1'b0;
    logic       sw0 = 1'b0;
    logic       sw1 = 1'b0;
    logic [3:0] rdy0 = 4'b1111;
    logic       rdy1 = 1'b1;
    logic [3:0] o_rst_n0;
    logic       o_done0;
    logic [0:0] o_rst_n1;
    logic       o_done1;
    int         checks = 0;
    int         failures = 0;
    int         en = 0;

    always #5 if (clk_en) clk = ~clk;

    rst_seq d0 (
        .clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(sw0),
`ifdef RST_SEQ_READY_EN
        .i_ch_rdy(rdy0),
`endif
        .o_rst_n(o_rst_n0), .o_done(o_done0)
    );

    rst_seq #(.G_NUM_CH(1), .G_SYNC_STAGES(3), .G_MIN_ASSERT(1), .G_REL_GAP(8)) d1 (
        .clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(sw1),
`ifdef RST_SEQ_READY_EN
        .i_ch_rdy(rdy1),
`endif
        .o_rst_n(o_rst_n1), .o_done(o_done1)
    );

    function automatic logic [3:0] seq_exp(int e, int s);
        for (int k = 0; k < 4; k++) seq_exp[k] = (e >= s + 8 * k);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        en++;
    endtask

    task automatic por;
        @(negedge clk);
        i_rst_n = 1'b0;
        sw0 = 1'b0;
        #2;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        en = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (o_rst_n0 !== 4'b0000 || o_done0 !== 1'b0 || o_rst_n1 !== 1'b0 || o_done1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rst_n0=%b done0=%b rst_n1=%b done1=%b want 0000 0 0 0",
                     o_rst_n0, o_done0, o_rst_n1, o_done1);
        end
    endtask

    task automatic test_power_on;
        por();
        for (int i = 0; i < 45; i++) begin
            tick();
            checks++;
            if (o_rst_n0 !== seq_exp(en, 18) || o_done0 !== (en >= 42)) begin
                failures++;
                $display("FAIL power_on edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0,
                         seq_exp(en, 18), en >= 42);
            end
            checks++;
            if (o_rst_n1 !== (en >= 4) || o_done1 !== (en >= 4)) begin
                failures++;
                $display("FAIL single_ch edge %0d got %b/%b want %b/%b", en, o_rst_n1, o_done1,
                         en >= 4, en >= 4);
            end
        end
    endtask

    task automatic test_async_assert;
        clk_en = 1'b0;
        #12;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_rst_n0 !== 4'b0000 || o_done0 !== 1'b0 || o_rst_n1 !== 1'b0 || o_done1 !== 1'b0) begin
            failures++;
            $display("FAIL async_assert got %b/%b %b/%b want 0000/0 0/0", o_rst_n0, o_done0,
                     o_rst_n1, o_done1);
        end
        #3;
        i_rst_n = 1'b1;
        #2;
        clk_en = 1'b1;
        en = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            checks++;
            if (o_rst_n0 !== seq_exp(en, 18) || o_done0 !== (en >= 42)) begin
                failures++;
                $display("FAIL async_restart edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0,
                         seq_exp(en, 18), en >= 42);
            end
        end
    endtask

    task automatic test_glitch;
        i_rst_n = 1'b0;
        #2;
        checks++;
        if (o_rst_n0 !== 4'b0000 || o_done0 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_clear got %b/%b want 0000/0", o_rst_n0, o_done0);
        end
        i_rst_n = 1'b1;
        en = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            checks++;
            if (o_rst_n0 !== seq_exp(en, 18) || o_done0 !== (en >= 42)) begin
                failures++;
                $display("FAIL glitch_restart edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0,
                         seq_exp(en, 18), en >= 42);
            end
        end
    endtask

    task automatic test_sw_in_rst;
        por();
        sw0 = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (en == 3) sw0 = 1'b0;
            checks++;
            if (o_rst_n0 !== seq_exp(en, 18) || o_done0 !== (en >= 42)) begin
                failures++;
                $display("FAIL sw_in_rst edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0,
                         seq_exp(en, 18), en >= 42);
            end
        end
    endtask

    task automatic test_sw_done;
        logic [3:0] ev;
        logic       ed;
        por();
        for (int i = 0; i < 145; i++) begin
            sw0 = (en + 1 >= 100) && (en + 1 <= 102);
            tick();
            ev = (en < 100) ? seq_exp(en, 18) : seq_exp(en, 118);
            ed = (en < 100) ? (en >= 42) : (en >= 142);
            checks++;
            if (o_rst_n0 !== ev || o_done0 !== ed) begin
                failures++;
                $display("FAIL sw_done edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0, ev, ed);
            end
        end
        sw0 = 1'b0;
    endtask

    task automatic test_mid_seq;
        logic [3:0] ev;
        logic       ed;
        por();
        for (int i = 0; i < 75; i++) begin
            sw0 = (en + 1 == 30);
            tick();
            ev = (en < 30) ? seq_exp(en, 18) : seq_exp(en, 46);
            ed = (en >= 30) && (en >= 70);
            checks++;
            if (o_rst_n0 !== ev || o_done0 !== ed) begin
                failures++;
                $display("FAIL mid_seq_sw edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0, ev, ed);
            end
        end
        sw0 = 1'b0;
    endtask

`ifdef RST_SEQ_READY_EN
    task automatic test_ready;
        logic [3:0] ev;
        rdy0 = 4'b1101;
        por();
        for (int i = 0; i < 75; i++) begin
            tick();
            if (en == 60) rdy0 = 4'b1111;
            ev = {en >= 69, en >= 61, en >= 26, en >= 18};
            checks++;
            if (o_rst_n0 !== ev || o_done0 !== (en >= 69)) begin
                failures++;
                $display("FAIL ready_gate edge %0d got %b/%b want %b/%b", en, o_rst_n0, o_done0,
                         ev, en >= 69);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_on();
        test_async_assert();
        test_glitch();
        test_sw_in_rst();
        test_sw_done();
        test_mid_seq();
`ifdef RST_SEQ_READY_EN
        test_ready();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
